// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph constants for the seg7_scan display driver.
//   bcd_t / bcd4_t : one BCD digit / the four MM:SS digits {d3,d2,d1,d0}
//   seg_t          : active-low cathode pattern {g,f,e,d,c,b,a}
//   digit_idx_t    : scan slot index 0..3
//   lz_blank()     : leading-zero blank test for one digit position
package seg7_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [1:0]       digit_idx_t;

    typedef struct packed {
        bcd_t d3;   // minutes tens
        bcd_t d2;   // minutes units
        bcd_t d1;   // seconds tens
        bcd_t d0;   // seconds units
    } bcd4_t;

    localparam seg_t SEG_OFF  = 7'h7F;
    localparam seg_t SEG_DASH = 7'b0111111;

    localparam seg_t GLYPH_0 = 7'b1000000;
    localparam seg_t GLYPH_1 = 7'b1111001;
    localparam seg_t GLYPH_2 = 7'b0100100;
    localparam seg_t GLYPH_3 = 7'b0110000;
    localparam seg_t GLYPH_4 = 7'b0011001;
    localparam seg_t GLYPH_5 = 7'b0010010;
    localparam seg_t GLYPH_6 = 7'b0000010;
    localparam seg_t GLYPH_7 = 7'b1111000;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0010000;

    // A digit is blanked only if it and every more-significant digit is zero;
    // non-BCD codes count as nonzero. d0 is never blanked.
    function automatic logic lz_blank(input bcd4_t d, input digit_idx_t i);
        logic z3, z2, z1;
        z3 = (d.d3 == 4'd0);
        z2 = (d.d2 == 4'd0);
        z1 = (d.d1 == 4'd0);
        case (i)
            2'd3:    return z3;
            2'd2:    return z3 && z2;
            2'd1:    return z3 && z2 && z1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit input bundle and display drive bundle of seg7_scan.
//   digits   : {d3,d2,d1,d0} BCD from the countdown counters
//   done     : timer expired, blink while high
//   blank_lz : leading-zero blanking enable
//   an/seg/dp: active-low anodes, cathodes {g..a}, decimal point
// master = producer of digits/controls (and consumer of display drive),
// slave  = the scan driver.
interface seg7_scan_if import seg7_pkg::*; ();

    bcd4_t      digits;
    logic       done;
    logic       blank_lz;
    logic [3:0] an;
    seg_t       seg;
    logic       dp;

    modport master (
        output digits, done, blank_lz,
        input  an, seg, dp
    );

    modport slave (
        input  digits, done, blank_lz,
        output an, seg, dp
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD -> active-low seven-segment glyph.
//   bcd   in  4  digit value; 10-15 decode to a dash
//   seg_c out 7  {g,f,e,d,c,b,a}, active low
module seg7_decode import seg7_pkg::*; (
    input  bcd_t bcd,
    output seg_t seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = GLYPH_0;
            4'd1:    seg_c = GLYPH_1;
            4'd2:    seg_c = GLYPH_2;
            4'd3:    seg_c = GLYPH_3;
            4'd4:    seg_c = GLYPH_4;
            4'd5:    seg_c = GLYPH_5;
            4'd6:    seg_c = GLYPH_6;
            4'd7:    seg_c = GLYPH_7;
            4'd8:    seg_c = GLYPH_8;
            4'd9:    seg_c = GLYPH_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: 4-digit multiplexed active-low seven-segment driver for MM:SS.
//   clk   in   system clock
//   reset in   synchronous, active-high
//   bus   slave of seg7_scan_if (digits, done, blank_lz in; an, seg, dp out)
// Scan prescaler, guard blanking at the start of each slot, frame-boundary
// snapshot of the digits, leading-zero blanking and blink while done.
// Outputs are registered (one cycle behind the scan state).
// Optional: define SEG7_COLON_DP_EN to light dp on the minutes-units digit
// as the MM.SS separator; otherwise dp is held off.
module seg7_scan import seg7_pkg::*; #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned GUARD       = 16,
    parameter int unsigned BLINK_SLOTS = 256
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  bus
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_SLOTS - 1);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    bcd4_t            snap;
    logic [BLK_W-1:0] blink_cnt;
    logic             phase;

    logic [3:0]       an_r;
    seg_t             seg_r;
    logic             dp_r;

    logic             slot_tick;
    bcd_t             cur_digit;
    seg_t             glyph;
    logic             lit;
    logic [3:0]       an_d;
    logic             dp_d;

    assign slot_tick = (cnt == CNT_LAST);

    // Scan timing, frame snapshot and blink phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            idx       <= '0;
            snap      <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            cnt <= slot_tick ? '0 : cnt + CNT_W'(1);

            if (slot_tick) begin
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap <= bus.digits;
                end
            end

            if (!bus.done) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (slot_tick) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BLK_W'(1);
                end
            end
        end
    end

    // Select the digit of the current slot.
    always_comb begin
        cur_digit = snap.d0;
        case (idx)
            2'd0: cur_digit = snap.d0;
            2'd1: cur_digit = snap.d1;
            2'd2: cur_digit = snap.d2;
            2'd3: cur_digit = snap.d3;
            default: cur_digit = snap.d0;
        endcase
    end

    seg7_decode u_decode (
        .bcd   (cur_digit),
        .seg_c (glyph)
    );

    // Anode/dp drive: blink-off, then guard, then leading-zero blank.
    always_comb begin
        an_d = 4'b1111;
        dp_d = 1'b1;
        lit  = (cnt >= CNT_GUARD) && !phase &&
               !(bus.blank_lz && lz_blank(snap, idx));
        if (lit) begin
            an_d[idx] = 1'b0;
        end
`ifdef SEG7_COLON_DP_EN
        if (lit && (idx == 2'd2)) begin
            dp_d = 1'b0;
        end
`else
        dp_d = 1'b1;
`endif
    end

    // Registered display drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= 4'b1111;
            seg_r <= SEG_OFF;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_d;
            seg_r <= glyph;
            dp_r  <= dp_d;
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed bench for seg7_scan with SCAN_DIV=8, GUARD=2,
// BLINK_SLOTS=4. Positions are tracked as (frame, slot, cycle-in-slot) from
// the first clock edge after reset release; output sampled 1 ns after an
// edge reflects the scan state just before that edge.
module tb_seg7_scan;
    import seg7_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   k;

`ifdef SEG7_COLON_DP_EN
    localparam logic DP_IDX2 = 1'b0;
`else
    localparam logic DP_IDX2 = 1'b1;
`endif

    seg7_scan_if bus ();

    seg7_scan #(
        .SCAN_DIV    (8),
        .GUARD       (2),
        .BLINK_SLOTS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic go(input int f, input int s, input int p);
        while (k < f * 32 + s * 8 + p) tick();
    endtask

    task automatic look(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        chk({tag, ".an"}, 16'(bus.an), 16'(an_e));
        chk({tag, ".seg"}, 16'(bus.seg), 16'(seg_e));
    endtask

    initial begin
        reset        = 1'b1;
        bus.digits   = '0;
        bus.done     = 1'b0;
        bus.blank_lz = 1'b1;
        k            = 0;
        repeat (3) tick();
        reset = 1'b0;
        k     = -1;

        // Reset mid-slot while d0 is lit.
        go(0, 0, 4);
        look("pre_rst", 4'hE, 7'h40);
        reset = 1'b1;
        tick();
        look("rst", 4'hF, 7'h7F);
        chk("rst.dp", 16'(bus.dp), 16'h1);
        tick();
        reset = 1'b0;
        k     = -1;

        // First frame after reset: only d0 shows 0, others blanked.
        go(0, 0, 1); chk("f0_guard.an", 16'(bus.an), 16'hF);
        go(0, 0, 2); look("f0_d0", 4'hE, 7'h40);
        go(0, 1, 5); chk("f0_d1.an", 16'(bus.an), 16'hF);
        go(0, 2, 5); chk("f0_d2.an", 16'(bus.an), 16'hF);
        go(0, 3, 5); chk("f0_d3.an", 16'(bus.an), 16'hF);
        bus.digits   = 16'h1234;
        bus.blank_lz = 1'b0;

        // 1234 without blanking, plus guard at slot starts.
        go(1, 0, 1); look("f1_guard0", 4'hF, 7'h19);
        go(1, 0, 2); look("f1_d0", 4'hE, 7'h19);
        go(1, 0, 7); chk("f1_d0_end.an", 16'(bus.an), 16'hE);
        go(1, 1, 0); chk("f1_guard1.an", 16'(bus.an), 16'hF);
        go(1, 1, 3); look("f1_d1", 4'hD, 7'h30);
        go(1, 2, 1); chk("f1_guard2.dp", 16'(bus.dp), 16'h1);
        go(1, 2, 6); look("f1_d2", 4'hB, 7'h24);
        chk("f1_d2.dp", 16'(bus.dp), 16'(DP_IDX2));
        go(1, 3, 2); look("f1_d3", 4'h7, 7'h79);
        chk("f1_d3.dp", 16'(bus.dp), 16'h1);

        // Mid-frame change must not tear.
        go(2, 1, 4);
        bus.digits = 16'h5678;
        go(2, 2, 4); look("tear_d2", 4'hB, 7'h24);
        go(2, 3, 4); look("tear_d3", 4'h7, 7'h79);
        go(3, 0, 4); look("f3_d0", 4'hE, 7'h00);
        go(3, 1, 4); look("f3_d1", 4'hD, 7'h78);
        go(3, 2, 4); look("f3_d2", 4'hB, 7'h02);
        go(3, 3, 4); look("f3_d3", 4'h7, 7'h12);
        bus.digits   = 16'h0050;
        bus.blank_lz = 1'b1;

        // Leading-zero blanking of 0050.
        go(4, 0, 4); look("lz_d0", 4'hE, 7'h40);
        go(4, 1, 4); look("lz_d1", 4'hD, 7'h12);
        go(4, 2, 4); chk("lz_d2.an", 16'(bus.an), 16'hF);
        go(4, 3, 4); chk("lz_d3.an", 16'(bus.an), 16'hF);
        bus.digits = 16'h00A0;

        // Non-BCD digit shows a dash and is not treated as zero.
        go(5, 1, 4); look("dash_d1", 4'hD, 7'h3F);
        go(5, 2, 4); chk("dash_d2.an", 16'(bus.an), 16'hF);
        go(5, 3, 4); chk("dash_d3.an", 16'(bus.an), 16'hF);
        bus.digits   = 16'h1234;
        bus.blank_lz = 1'b0;
        bus.done     = 1'b1;

        // Blink: 4 slot ticks on, 4 off, repeating.
        go(6, 2, 7); look("blk_on0", 4'hB, 7'h24);
        go(6, 3, 0); chk("blk_off0.an", 16'(bus.an), 16'hF);
        go(6, 3, 5); chk("blk_off1.an", 16'(bus.an), 16'hF);
        go(7, 0, 5); chk("blk_off2.an", 16'(bus.an), 16'hF);
        go(7, 2, 7); chk("blk_off3.an", 16'(bus.an), 16'hF);
        chk("blk_off3.dp", 16'(bus.dp), 16'h1);
        go(7, 3, 2); look("blk_on1", 4'h7, 7'h79);
        go(8, 0, 4); chk("blk_on2.an", 16'(bus.an), 16'hE);
        go(8, 2, 7); chk("blk_on3.an", 16'(bus.an), 16'hB);
        chk("blk_on3.dp", 16'(bus.dp), 16'(DP_IDX2));
        go(8, 3, 2); chk("blk_off4.an", 16'(bus.an), 16'hF);
        go(8, 3, 4); chk("blk_off5.an", 16'(bus.an), 16'hF);
        bus.done = 1'b0;

        // Dropping done during the off phase restores the display.
        go(8, 3, 6); look("undone", 4'h7, 7'h79);
        go(9, 0, 4); chk("undone_d0.an", 16'(bus.an), 16'hE);
        go(9, 2, 5); look("undone_d2", 4'hB, 7'h24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream consumer of the countdown digit counters: mod10 seconds-units, the tens stage and the minutes stages.
- Takes four BCD digits (MM:SS) and drives a 4-digit multiplexed, active-low seven-segment display.
- Provides scan timing, anti-ghost guard blanking, frame-synchronous snapshot (no tearing), leading-zero blanking and blink on timer done.

Parameters:
- SCAN_DIV, 100000, clocks per digit slot (must be > GUARD).
- GUARD, 16, clocks at start of each slot with all anodes off.
- BLINK_SLOTS, 256, slot ticks per blink half-period.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- digits  in  16  {d3,d2,d1,d0} BCD; d0 = seconds units, d3 = minutes tens.
- done  in  1  timer expired; blink display while high.
- blank_lz  in  1  enable leading-zero blanking.
- an  out  4  anodes, active low; an[i] selects digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active low.
- dp  out  1  decimal point, active low.

Behaviour:
- Reset (synchronous, same cycle):
  - cnt=0, idx=0, snap=0, blink_cnt=0, phase=0.
  - an=4'b1111, seg=7'h7F, dp=1.
- Prescaler: cnt counts 0..SCAN_DIV-1 and wraps. slot_tick = (cnt==SCAN_DIV-1).
- Scan index: idx 0..3 advances on slot_tick, wraps 3->0.
- Snapshot:
  - On slot_tick with idx==3, snap<=digits (frame boundary).
  - Digits changing mid-frame are not shown until the next frame.
- Decode:
  - 0-9 use standard glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10-15 display a dash (0111111).
- Leading-zero blanking (blank_lz=1, evaluated on snap):
  - d3 blanked if d3==0.
  - d2 blanked if d3==d2==0.
  - d1 blanked if d3==d2==d1==0.
  - d0 never blanked.
  - Values 10-15 count as nonzero.
- Blink:
  - While done=1, blink_cnt counts slot_ticks. When it reaches BLINK_SLOTS-1, it clears and phase toggles.
  - phase=1 forces an=1111.
  - done=0 clears blink_cnt and phase, so the display is on.
  - After done rises, the display stays on for the first BLINK_SLOTS slots.
- Output stage:
  - an, seg and dp are registered from idx, cnt, snap, phase and blank_lz, giving 1-cycle latency.
  - an[idx]=0 only when cnt>=GUARD, the digit is not blanked, and phase==0. Otherwise an=1111.
  - seg always carries the decoded glyph of snap[idx].
- Precedence: reset > blink-off > guard > leading-zero blank > normal display.
- Simultaneous events: slot_tick plus a blink toggle in the same cycle is legal. Both take effect on the next registered output.

Optional Feature:
- Macro: SEG7_COLON_DP_EN.
- Defined: dp=0 while the active digit is idx==2 (minutes units) and its anode is on, forming the MM.SS separator. Follows guard and blink.
- Undefined: dp is tied to 1.

Decomposition:
- Package seg7_pkg holds:
  - SEG_OFF=7'h7F and SEG_DASH=7'b0111111.
  - The digit glyph constants.
  - A 2-bit digit-index type.
- Sub-module seg7_decode: combinational 4-bit BCD -> 7-bit active-low segment pattern, instantiated once on snap[idx].

Test Plan:
Benches use SCAN_DIV=8, GUARD=2, BLINK_SLOTS=4.
- Reset asserted mid-slot -> next cycle an=1111, seg=7F, dp=1. After release with blank_lz=1, the first frame shows only an=1110 with seg=1000000.
- digits=16'h1234, blank_lz=0, after one frame:
  - idx0: an=1110, seg=0011001.
  - idx1: an=1101, seg=0110000.
  - idx2: an=1011, seg=0100100.
  - idx3: an=0111, seg=1111001.
- Guard -> first 2 cycles of every slot an=1111; remaining 6 cycles the digit is on.
- blank_lz=1, digits=16'h0050:
  - an[3] and an[2] are never low.
  - d1 shows 0010010.
  - d0 shows 1000000.
  - digits=16'h00A0 -> d1 shows 0111111.
- Tearing: change 1234->5678 during idx1 -> idx2/3 still show 2/1. The next frame shows 8,7,6,5.
- Blink and dp:
  - done=1 -> 4 slots on, 4 slots an=1111, repeating.
  - Dropping done during the off phase -> display on 1 cycle later.
  - With SEG7_COLON_DP_EN, dp=0 only during idx2 lit cycles.
